// File: rtl/seq_addsub_pkg.sv
// rtl/seq_addsub_pkg.sv - shared op/state encodings and sizing helpers for seq_addsub
package seq_addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Guarded so an illegal CHUNK reaches the parameter check instead of dividing by zero.
    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// rtl/seq_addsub_chunk.sv - combinational CHUNK-bit adder slice with carry in/out
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s     = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle chunked add/subtract unit with valid/ready handshakes
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_addsub: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, sum_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry, carry0;
    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic             c_k;
    logic             accept, last;

    assign a_k    = a_r[idx*CHUNK +: CHUNK];
    assign b_k    = b_r[idx*CHUNK +: CHUNK];
    assign last   = (idx == LAST_IDX);
    assign accept = in_valid && (state == S_IDLE);

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_k),
        .b    (b_k),
        .cin  (carry),
        .s    (s_k),
        .cout (c_k)
    );

    // Full result with the current chunk merged in, so flags can register alongside it.
    always_comb begin
        sum_nxt = sum;
        sum_nxt[idx*CHUNK +: CHUNK] = s_k;
    end

    // Subtraction is a + ~b + carry0, where carry0=1 is "no borrow in".
    always_comb begin
        carry0 = 1'b0;
        case (op)
            OP_ADD:  carry0 = 1'b0;
            OP_ADDC: carry0 = cin;
            OP_SUB:  carry0 = 1'b1;
            OP_SUBB: carry0 = cin;
            default: carry0 = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r   <= a;
                b_r   <= op[1] ? ~b : b;
                carry <= carry0;
                idx   <= '0;
            end else if (state == S_BUSY) begin
                sum   <= sum_nxt;
                carry <= c_k;
                idx   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    cout <= c_k;
                    ovf  <= (a_r[MSB] == b_r[MSB]) && (sum_nxt[MSB] != a_r[MSB]);
                    zero <= ~|sum_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - self-checking bench for seq_addsub across several WIDTH/CHUNK configs
module tb_seq_addsub;
    import seq_addsub_pkg::*;

    localparam int NI = 5;

    function automatic int w_of(input int i);
        return (i == 4) ? 32 : 16;
    endfunction

    function automatic int c_of(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 8;
            3: return 16;
            default: return 8;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] iv, ir, ov, ordy, cin_v, co, of, zr;
    logic [1:0]    op_v  [NI];
    logic [31:0]   a_v   [NI];
    logic [31:0]   b_v   [NI];
    logic [31:0]   sum_v [NI];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int W = w_of(g);
            localparam int C = c_of(g);
            logic [W-1:0] s;
            seq_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .a         (a_v[g][W-1:0]),
                .b         (b_v[g][W-1:0]),
                .op        (op_v[g]),
                .cin       (cin_v[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .sum       (s),
                .cout      (co[g]),
                .ovf       (of[g]),
                .zero      (zr[g])
            );
            assign sum_v[g] = 32'(s);
        end
    endgenerate

    // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
    task automatic ref_model(input int w, input logic [1:0] o, input logic [31:0] aa,
                             input logic [31:0] bb, input logic c, output logic [31:0] s,
                             output logic co_o, output logic of_o, output logic zr_o);
        longint m, ua, ub, sa, sb, ures, sres, hi, lo, ci;
        m  = (longint'(1) << w) - 1;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        ua = longint'(aa) & m;
        ub = longint'(bb) & m;
        sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
        sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
        ci = c ? 1 : 0;
        case (o)
            OP_ADD:  begin ures = ua + ub;          sres = sa + sb;          co_o = (ures > m);  end
            OP_ADDC: begin ures = ua + ub + ci;     sres = sa + sb + ci;     co_o = (ures > m);  end
            OP_SUB:  begin ures = ua - ub;          sres = sa - sb;          co_o = (ures >= 0); end
            default: begin ures = ua - ub - (1 - ci); sres = sa - sb - (1 - ci); co_o = (ures >= 0); end
        endcase
        s    = 32'(ures & m);
        of_o = (sres > hi) || (sres < lo);
        zr_o = ((ures & m) == 0);
    endtask

    // Issues one op, scrambles inputs while busy, measures latency; handoff unless hold.
    task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic c, input bit hold,
                          output int lat, output logic [31:0] s, output logic co_o,
                          output logic of_o, output logic zr_o);
        @(negedge clk);
        a_v[i] = aa; b_v[i] = bb; op_v[i] = o; cin_v[i] = c;
        iv[i] = 1'b1; ordy[i] = 1'b0;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            a_v[i] = $urandom; b_v[i] = $urandom;
            op_v[i] = 2'($urandom_range(3)); cin_v[i] = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            if (ov[i]) begin
                lat = n;
                break;
            end
        end
        s = sum_v[i]; co_o = co[i]; of_o = of[i]; zr_o = zr[i];
        if (!hold) begin
            ordy[i] = 1'b1;
            @(posedge clk);
            #1;
            ordy[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        iv  = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir[0]); end
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov[0]); end
        checks++; if (sum_v[0] !== 32'h0) begin errors++; $display("FAIL reset_sum got %h exp 0", sum_v[0]); end
        checks++; if (co[0] !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", co[0]); end
        checks++; if (of[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", of[0]); end
        checks++; if (zr[0] !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zr[0]); end
        @(negedge clk);
        iv  = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ir !== {NI{1'b1}}) begin errors++; $display("FAIL reset_no_accept in_ready got %b exp all ones", ir); end
        checks++; if (ov !== '0) begin errors++; $display("FAIL reset_post_out_valid got %b exp 0", ov); end
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [4] = '{OP_ADD, OP_SUB, OP_SUBB, OP_ADDC};
        logic [31:0] t_a  [4] = '{32'hFFFF, 32'h8000, 32'h0000, 32'h7FFF};
        logic [31:0] t_b  [4] = '{32'h0001, 32'h0001, 32'h0000, 32'h0000};
        logic        t_c  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] t_s  [4] = '{32'h0000, 32'h7FFF, 32'hFFFF, 32'h8000};
        logic        t_co [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        t_of [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        t_zr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        logic [31:0] s;
        logic c_o, o_o, z_o;
        for (int k = 0; k < 4; k++) begin
            run_op(0, t_op[k], t_a[k], t_b[k], t_c[k], 1'b0, lat, s, c_o, o_o, z_o);
            checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got %0d exp 4", k, lat); end
            checks++; if (s !== t_s[k]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", k, s, t_s[k]); end
            checks++; if (c_o !== t_co[k]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", k, c_o, t_co[k]); end
            checks++; if (o_o !== t_of[k]) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", k, o_o, t_of[k]); end
            checks++; if (z_o !== t_zr[k]) begin errors++; $display("FAIL dir%0d_zero got %b exp %b", k, z_o, t_zr[k]); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] aa, bb, s, es;
        logic c_o, o_o, z_o, ec, eo, ez;
        int lat;
        aa = 32'($urandom_range(16'hFFFF));
        bb = 32'($urandom_range(16'hFFFF));
        ref_model(16, OP_SUB, aa, bb, 1'b0, es, ec, eo, ez);
        run_op(0, OP_SUB, aa, bb, 1'b0, 1'b1, lat, s, c_o, o_o, z_o);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", lat); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv[0] = 1'b1; a_v[0] = $urandom; b_v[0] = $urandom; op_v[0] = 2'($urandom_range(3));
            @(posedge clk);
            #1;
            checks++; if (sum_v[0] !== es) begin errors++; $display("FAIL bp_sum cyc%0d got %h exp %h", k, sum_v[0], es); end
            checks++; if ({co[0], of[0], zr[0]} !== {ec, eo, ez}) begin errors++; $display("FAIL bp_flags cyc%0d got %b exp %b", k, {co[0], of[0], zr[0]}, {ec, eo, ez}); end
            checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b exp 0", k, ir[0]); end
            checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d got %b exp 1", k, ov[0]); end
        end
        @(negedge clk);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", ov[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", ir[0]); end
    endtask

    task automatic test_reset_mid_busy;
        logic seen;
        @(negedge clk);
        a_v[0] = 32'h1234; b_v[0] = 32'h4321; op_v[0] = OP_ADD; cin_v[0] = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", ov[0]); end
        checks++; if (sum_v[0] !== 32'h0) begin errors++; $display("FAIL midrst_sum got %h exp 0", sum_v[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", ir[0]); end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            seen = seen | ov[0];
        end
        ordy[0] = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_never_valid got %b exp 0", seen); end
    endtask

    task automatic test_random;
        logic [31:0] aa, bb, s, es, mask;
        logic [1:0] o;
        logic c, c_o, o_o, z_o, ec, eo, ez;
        int lat, w, nch;
        for (int i = 0; i < NI; i++) begin
            w    = w_of(i);
            nch  = w / c_of(i);
            mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            for (int k = 0; k < 200; k++) begin
                o  = 2'($urandom_range(3));
                c  = 1'($urandom_range(1));
                aa = ($urandom_range(7) == 0) ? mask : ($urandom & mask);
                bb = ($urandom_range(7) == 0) ? 32'h0 : ($urandom & mask);
                ref_model(w, o, aa, bb, c, es, ec, eo, ez);
                run_op(i, o, aa, bb, c, 1'b0, lat, s, c_o, o_o, z_o);
                checks++; if (lat !== nch) begin errors++; $display("FAIL rand_latency inst%0d: ERRORCHECK got %0d exp %0d", i, lat, nch); end
                checks++; if (s !== es) begin errors++; $display("FAIL rand_sum inst%0d op%0d a=%h b=%h cin=%b: ERRORCHECK got %h exp %h", i, o, aa, bb, c, s, es); end
                checks++; if (c_o !== ec) begin errors++; $display("FAIL rand_cout inst%0d op%0d a=%h b=%h cin=%b: ERRORCHECK got %b exp %b", i, o, aa, bb, c, c_o, ec); end
                checks++; if (o_o !== eo) begin errors++; $display("FAIL rand_ovf inst%0d op%0d a=%h b=%h cin=%b: ERRORCHECK got %b exp %b", i, o, aa, bb, c, o_o, eo); end
                checks++; if (z_o !== ez) begin errors++; $display("FAIL rand_zero inst%0d op%0d a=%h b=%h cin=%b: ERRORCHECK got %b exp %b", i, o, aa, bb, c, z_o, ez); end
            end
        end
    endtask

    initial begin
        iv = '0; ordy = '0; cin_v = '0;
        for (int i = 0; i < NI; i++) begin
            a_v[i] = '0; b_v[i] = '0; op_v[i] = OP_ADD;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
